// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the ID-stage decoder:
// MD opcode encoding, default iteration counts and the unit's state type.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_MUL_CYCLES = 5;
    localparam int MD_DIV_CYCLES = 10;

    typedef enum logic {
        MD_ST_IDLE = 1'b0,
        MD_ST_RUN  = 1'b1
    } md_state_t;

    function automatic int md_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// The 64-bit result is computed at issue and parked in phi/plo; a down
// counter then models the iteration latency and HI/LO commit at its end.
//
// Issue handshake: an op is accepted on a rising edge where
// start & ~cancel & ~busy & (op != MD_NONE). There is no ready signal;
// busy is the back-pressure, and start while busy is dropped (the hazard
// unit never does this). An accepted multi-cycle op cannot be cancelled.
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MD_MUL_CYCLES,
    parameter int DIV_CYCLES = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(md_max(MUL_CYCLES, DIV_CYCLES) + 1);

    md_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      phi;
    logic [31:0]      plo;
    logic             pwe;

    logic             issue;
    logic             is_mul;
    logic             is_div;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_we;
    logic             div_ovf;
    logic [31:0]      b_safe;
    logic [63:0]      prod;
    logic [31:0]      quot;
    logic [31:0]      rem;

    // Decode the issue request and compute the full 64-bit result up front.
    always_comb begin
        issue   = start & ~cancel & ~busy & (op != MD_NONE);
        is_mul  = (op == MD_MULT) | (op == MD_MULTU);
        is_div  = (op == MD_DIV) | (op == MD_DIVU);
        // INT_MIN / -1 overflows the signed quotient; its architectural
        // answer is fixed below, so keep the divider on a harmless operand.
        div_ovf = (op == MD_DIV) & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        b_safe  = ((b == 32'd0) | div_ovf) ? 32'd1 : b;
        prod    = 64'd0;
        quot    = 32'd0;
        rem     = 32'd0;
        res_we  = 1'b1;
        case (op)
            MD_MULT:  prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            MD_MULTU: prod = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                quot = $signed(a) / $signed(b_safe);
                rem  = $signed(a) % $signed(b_safe);
            end
            MD_DIVU: begin
                quot = a / b_safe;
                rem  = a % b_safe;
            end
            default: ;
        endcase
        if (div_ovf) begin
            quot = 32'h8000_0000;
            rem  = 32'd0;
        end
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
            res_we = (b != 32'd0);
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // Control FSM, iteration counter, pending result and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            phi   <= 32'd0;
            plo   <= 32'd0;
            pwe   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                MD_ST_IDLE: begin
                    if (issue) begin
                        if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end else if (is_mul | is_div) begin
                            phi   <= res_hi;
                            plo   <= res_lo;
                            pwe   <= res_we;
                            cnt   <= is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy  <= 1'b1;
                            state <= MD_ST_RUN;
                        end
                    end
                end
                MD_ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (pwe) begin
                            hi <= phi;
                            lo <= plo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= MD_ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= MD_ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases followed by random ops,
// compared against a plain-arithmetic model of HI/LO and op latency.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] exp_q[$];

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result of an MD op from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic we, output logic [31:0] rh, output logic [31:0] rl);
        int           ix;
        int           iy;
        longint       lx;
        longint       ly;
        longint       r64;
        logic [63:0]  u64;
        ix = x;
        iy = y;
        lx = ix;
        ly = iy;
        we = 1'b1;
        rh = m_hi;
        rl = m_lo;
        case (o)
            MD_MULT: begin
                r64 = lx * ly;
                rh = r64[63:32];
                rl = r64[31:0];
            end
            MD_MULTU: begin
                u64 = {32'd0, x} * {32'd0, y};
                rh = u64[63:32];
                rl = u64[31:0];
            end
            MD_DIV: begin
                if (y == 0) we = 1'b0;
                else begin
                    r64 = lx / ly;
                    rl = r64[31:0];
                    r64 = lx % ly;
                    rh = r64[31:0];
                end
            end
            MD_DIVU: begin
                if (y == 0) we = 1'b0;
                else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: we = 1'b0;
        endcase
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    // Issue one op (called #1 after a rising edge), then follow busy until
    // the unit is idle again; returns in the first non-busy cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic c);
        int          n;
        int          exp_cycles;
        logic        we;
        logic [31:0] rh;
        logic [31:0] rl;
        logic [63:0] e;
        exp_cycles = 0;
        model(o, x, y, we, rh, rl);
        if (!c) begin
            if (o == MD_MTHI) m_hi = x;
            else if (o == MD_MTLO) m_lo = x;
            else if (o == MD_MULT || o == MD_MULTU) exp_cycles = MD_MUL_CYCLES;
            else if (o == MD_DIV || o == MD_DIVU) exp_cycles = MD_DIV_CYCLES;
        end
        if (exp_cycles != 0) exp_q.push_back(we ? {rh, rl} : {m_hi, m_lo});
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        cancel = c;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = MD_NONE;
        a      = $urandom;
        b      = $urandom;
        n = 0;
        if (busy) check({tag, " hold"}, {hi, lo}, {m_hi, m_lo});
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({tag, " busy_cycles"}, 64'(n), 64'(exp_cycles));
        if (exp_cycles != 0) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
        check({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic reset_mid_div();
        int n;
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = MD_NONE;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1);
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid hilo", {hi, lo}, 64'd0);
        n = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (busy || hi != 0 || lo != 0) n++;
        end
        check("rst_mid no_commit", 64'(n), 64'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        reset  = 1'b1;
        start  = 1'b0;
        op     = MD_NONE;
        a      = 32'd0;
        b      = 32'd0;
        cancel = 1'b0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        @(posedge clk);
        #1;
        do_reset(2);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);

        // directed
        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", MD_DIVU, 32'd7, 32'd2, 1'b0);
        check("divu const", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("mthi_aa", MD_MTHI, 32'hAA, 32'd0, 1'b0);
        run_op("mtlo_bb", MD_MTLO, 32'hBB, 32'd0, 1'b0);
        run_op("div0", MD_DIV, 32'd55, 32'd0, 1'b0);
        check("div0 const", {hi, lo}, 64'h0000_00AA_0000_00BB);
        run_op("divu0", MD_DIVU, 32'd55, 32'd0, 1'b0);
        run_op("mult_cancel", MD_MULT, 32'd3, 32'd4, 1'b1);
        check("mult_cancel const", {hi, lo}, 64'h0000_00AA_0000_00BB);
        run_op("none", MD_NONE, 32'd9, 32'd9, 1'b0);
        run_op("b2b_mult", MD_MULT, 32'd6, 32'hFFFF_FFFD, 1'b0);
        run_op("b2b_div", MD_DIV, 32'd20, 32'hFFFF_FFFA, 1'b0);
        check("b2b_div const", {hi, lo}, 64'h0000_0002_FFFF_FFFD);
        reset_mid_div();

        // random
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            rc = ($urandom_range(0, 9) == 0);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, rc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit in the EX stage, fed directly from the ID/EX pipeline register outputs (operands `rd1`/`rd2`, decoded MD opcode, `valid`). It owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. While an operation is in flight it drives `busy`, which the hazard unit uses to stall MD-class instructions in ID.

## Interface
- `MUL_CYCLES`, default 5: busy cycles for MULT/MULTU, legal range ≥1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU, legal range ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  an MD instruction in EX requests issue; already qualified with the EX `valid` bit.
- `op`  in  3  MD opcode, encoded per the shared package.
- `a`  in  32  rs operand, forwarded `rd1`.
- `b`  in  32  rt operand, forwarded `rd2`.
- `cancel`  in  1  exception or interrupt taken this cycle; suppresses issue.
- `busy`  out  1  operation in flight.
- `hi`  out  32  committed HI, registered.
- `lo`  out  32  committed LO, registered.

## Operation
- Issue condition: `start & ~cancel & ~busy & op != MD_NONE`. If `start` arrives while `busy` is high, it is ignored; the hazard unit guarantees this does not occur.
- MTHI/MTLO: `hi <= a` or `lo <= a` at the issue edge. `busy` stays low. No counter activity.
- MULT/MULTU/DIV/DIVU at issue:
  - Compute the 64-bit result from `a`/`b` and store it in the pending regs `phi`/`plo`.
  - Load the counter with `MUL_CYCLES` or `DIV_CYCLES`.
  - Set `busy`.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned 32×32→64. HI gets product[63:32]; LO gets product[31:0].
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
  - Divide by zero (`b == 0`): the op still runs for the full `DIV_CYCLES` and sets `busy`, but HI/LO are left unchanged at commit.
- State machine:
  - IDLE: `busy=0`. Goes to RUN on a MULT/MULTU/DIV/DIVU issue.
  - RUN: `busy=1`. Counter decrements each cycle. The commit edge is the edge at which the counter equals 1: `hi <= phi`, `lo <= plo`, and the state returns to IDLE.
- `cancel` has no effect on an op already in RUN, because that op has committed architecturally from the pipeline's view.
- While in RUN, `hi`/`lo` continue to show the old values. MFHI/MFLO must be stalled by the hazard unit on `busy`.

## Timing
- Reset values: `hi = 0`, `lo = 0`, `busy = 0`, `phi = plo = 0`, counter = 0, state = IDLE. A reset mid-operation aborts the op with no HI/LO commit.
- MTHI/MTLO: the new value is visible on `hi`/`lo` in the cycle after the issue edge.
- MULT issued at edge t:
  - `busy` is high in cycles t+1 … t+MUL_CYCLES.
  - The commit edge is t+MUL_CYCLES. The new HI/LO and `busy = 0` are visible in cycle t+MUL_CYCLES+1.
- DIV follows the same pattern with `DIV_CYCLES`.
- A new issue is legal in the first cycle `busy` is low, so back-to-back ops run with no gap.
- `start` together with `cancel` in the same cycle: no state change.

## Structure
- The shared package `md_pkg` holds:
  - the opcode constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6;
  - the default cycle counts.
- The decoder in ID uses the same package.
- Single module, no sub-module; the result is computed with behavioural operators at issue.
- The counter width is `$clog2(max(MUL_CYCLES, DIV_CYCLES)+1)`.

## Test plan
- Reset for 2 cycles, then check `hi = lo = 0` and `busy = 0`. Then MTHI a=0x12345678 → `hi = 0x12345678` one cycle later, `busy` never high.
- MULT a=0xFFFFFFFF, b=2 → `busy` high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 → `busy` high exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- Preload hi=0xAA and lo=0xBB via MTHI/MTLO, then DIV with b=0 → `busy` high for 10 cycles, and hi=0xAA, lo=0xBB after.
- MULT with `cancel` in the same cycle → `busy` stays 0 and HI/LO are unchanged. Assert `reset` 3 cycles into a DIV → next cycle `busy` = 0, hi = lo = 0, and no later commit.
- MULT immediately followed by DIV in the first non-busy cycle → both commit correct results, with no lost or duplicated commits.
